full_adder_core: RTL and testbench

Registered ripple-carry full adder. Adds two WIDTH-bit operands and a carry-in, and produces a WIDTH-bit sum and a carry-out. The default WIDTH=1 is a single-bit full adder with truth-table behaviour. It sits in the math library as the basic adder primitive that wider arithmetic blocks are built from.

---
 rtl/full_adder_core.sv | 67 ++++++
 tb/tb_full_adder_core.sv | 119 +++++++++++
 2 files changed

// File: rtl/full_adder_core.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin, one-cycle latency.
// The carry chain is built from explicit 1-bit cells so the ripple structure is visible.

module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             vld_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (carry[i]),
      .s_o (sum_d[i]),
      .c_o (carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH];

  // Result registers only load on valid input; otherwise the last result is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder_core.sv
// Checks full_adder_core at WIDTH=1, 8 and 16 against plain integer addition.

module tb_full_adder_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v1, a1, b1, c1, s1, co1, ov1;
  logic        v8, c8, co8, ov8;
  logic [7:0]  a8, b8, s8;
  logic        v16, c16, co16, ov16;
  logic [15:0] a16, b16, s16;

  int n_chk  = 0;
  int n_fail = 0;

  full_adder_core #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .cout(co1), .out_valid(ov1));

  full_adder_core #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .sum(s8), .cout(co8), .out_valid(ov8));

  full_adder_core #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
    .sum(s16), .cout(co16), .out_valid(ov16));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    int e;
    a8 = a; b8 = b; c8 = c; v8 = 1'b1;
    tick();
    e = int'(a) + int'(b) + int'(c);
    chk({tag, "_res"}, {55'd0, co8, s8}, 64'(e));
    chk({tag, "_vld"}, {63'd0, ov8}, 64'd1);
  endtask

  initial begin
    logic [16:0] exp16;
    rst = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v16 = 0; a16 = 0; b16 = 0; c16 = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_w1",  {61'd0, ov1, co1, s1}, 64'd0);
    chk("rst_w8",  {54'd0, ov8, co8, s8}, 64'd0);
    chk("rst_w16", {46'd0, ov16, co16, s16}, 64'd0);
    rst = 1'b0;

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] t;
      t = 3'(i);
      a1 = t[2]; b1 = t[1]; c1 = t[0]; v1 = 1'b1;
      tick();
      chk($sformatf("w1_tt%0d", i), {62'd0, co1, s1}, 64'(int'(t[2]) + int'(t[1]) + int'(t[0])));
      chk($sformatf("w1_vld%0d", i), {63'd0, ov1}, 64'd1);
    end
    v1 = 1'b0;

    // WIDTH=8 carry chain and back-to-back
    drv8(8'hFF, 8'h00, 1'b1, "w8_ripple");
    drv8(8'hFF, 8'hFF, 1'b1, "w8_allones");
    drv8(8'h00, 8'h00, 1'b0, "w8_zero");
    drv8(8'h12, 8'h34, 1'b0, "w8_b2b0");
    drv8(8'h80, 8'h80, 1'b0, "w8_b2b1");

    // Hold with no input
    v8 = 1'b0; a8 = 8'h55; b8 = 8'h0F; c8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("w8_hold%0d", i), {55'd0, co8, s8}, 64'h100);
      chk($sformatf("w8_hold_vld%0d", i), {63'd0, ov8}, 64'd0);
    end

    // Async reset between edges while a result is valid
    drv8(8'h01, 8'h01, 1'b0, "w8_pre_rst");
    v8 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("w8_async_rst", {54'd0, ov8, co8, s8}, 64'd0);
    chk("w1_async_rst", {61'd0, ov1, co1, s1}, 64'd0);
    rst = 1'b0;
    tick();
    chk("w8_post_rst", {54'd0, ov8, co8, s8}, 64'd0);

    // WIDTH=16 random, with occasional idle cycles
    exp16 = '0;
    for (int n = 0; n < 1000; n++) begin
      v16 = ($urandom_range(9) != 0);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      tick();
      if (v16) exp16 = 17'(int'(a16) + int'(b16) + int'(c16));
      chk($sformatf("w16_rnd%0d", n), {47'd0, co16, s16}, {47'd0, exp16});
      chk($sformatf("w16_vld%0d", n), {63'd0, ov16}, {63'd0, v16});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
